// File: rtl/sram_banked_if.sv
// Bus bundle for sram_banked: one read port and one lane-masked write port.
// The master drives addresses and write data; the slave (the array) returns readData.
interface sram_banked_if #(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 9,
  parameter int WORDSIZE = 64
);
  localparam int LANES = WIDTH / WORDSIZE;

  logic [LOGDEPTH-1:0] readAddr;
  logic [WIDTH-1:0]    readData;
  logic [LOGDEPTH-1:0] writeAddr;
  logic [WIDTH-1:0]    writeData;
  logic [LANES-1:0]    writeEnable;

  modport master (
    output readAddr,
    output writeAddr,
    output writeData,
    output writeEnable,
    input  readData
  );

  modport slave (
    input  readAddr,
    input  writeAddr,
    input  writeData,
    input  writeEnable,
    output readData
  );
endinterface

// File: rtl/sram_banked.sv
// 1R1W synchronous memory with per-lane write enables and registered read data.
// Read-before-write on address collision; extra output stages model deeper or multi-port arrays.
module sram_banked #(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 9,
  parameter int WORDSIZE = 64,
  parameter int PORTS    = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  sram_banked_if.slave bus
);
  localparam int LANES = WIDTH / WORDSIZE;
  localparam int DEPTH = 1 << LOGDEPTH;

  function automatic int latency_factor(input int ports);
    int f;
    case (ports)
      1:       f = 10;
      2:       f = 14;
      3:       f = 20;
      4:       f = 100;
      default: f = 10;
    endcase
    return f;
  endfunction

  localparam int ROW_SCALE = (LOGDEPTH > 8) ? (LOGDEPTH - 8) : 1;
  localparam int DELAY_RAW = (ROW_SCALE * latency_factor(PORTS)) / 10 - 1;
  localparam int DELAY     = (DELAY_RAW < 0) ? 0 : DELAY_RAW;

  if ((WIDTH % WORDSIZE) != 0 || PORTS < 1 || PORTS > 4) begin : g_bad_params
    $fatal(1, "sram_banked: WIDTH must be a multiple of WORDSIZE and PORTS must be 1..4");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  // Lane-masked write; contents are never cleared and writes are dropped while in reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.writeEnable[k]) begin
          mem_q[bus.writeAddr][k*WORDSIZE +: WORDSIZE] <= bus.writeData[k*WORDSIZE +: WORDSIZE];
        end
      end
    end
  end

  // Array read sees the pre-write row, giving read-before-write on collision.
  always_comb begin
    rd_d = mem_q[bus.readAddr];
  end

  // Array read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  if (DELAY > 0) begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DELAY];

    // Output delay line, one new read accepted every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DELAY; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= rd_q;
        for (int i = 1; i < DELAY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign bus.readData = pipe_q[DELAY-1];
  end else begin : g_nopipe
    assign bus.readData = rd_q;
  end
endmodule

// File: tb/tb_sram_banked.sv
// Directed scoreboard bench for sram_banked: 8-lane data array, single-lane tag array,
// and a LOGDEPTH=10/PORTS=2 instance whose read latency is two edges.
module tb_sram_banked;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    bit          chk;
    logic [511:0] exp;
  } sb_t;

  sb_t mq[$];
  sb_t tq[$];
  sb_t pq[$];

  logic [511:0] m_mem [int];
  logic [49:0]  t_mem [int];
  logic [63:0]  p_mem [int];

  always #5 clk = ~clk;

  sram_banked_if #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64)) m_if ();
  sram_banked_if #(.WIDTH(50), .LOGDEPTH(9), .WORDSIZE(50))  t_if ();
  sram_banked_if #(.WIDTH(64), .LOGDEPTH(10), .WORDSIZE(64)) p_if ();

  sram_banked #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64), .PORTS(1)) u_main (
    .clk(clk), .reset_n(reset_n), .bus(m_if.slave)
  );
  sram_banked #(.WIDTH(50), .LOGDEPTH(9), .WORDSIZE(50), .PORTS(1)) u_tag (
    .clk(clk), .reset_n(reset_n), .bus(t_if.slave)
  );
  sram_banked #(.WIDTH(64), .LOGDEPTH(10), .WORDSIZE(64), .PORTS(2)) u_pipe (
    .clk(clk), .reset_n(reset_n), .bus(p_if.slave)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic main_cycle(input logic [8:0] ra, input logic [8:0] wa,
                            input logic [511:0] wd, input logic [7:0] we, input bit chk);
    sb_t e;
    logic [511:0] cur;
    m_if.readAddr = ra; m_if.writeAddr = wa; m_if.writeData = wd; m_if.writeEnable = we;
    e.chk = chk;
    e.exp = chk ? m_mem[int'(ra)] : '0;
    mq.push_back(e);
    if (we != 8'h00) begin
      cur = m_mem.exists(int'(wa)) ? m_mem[int'(wa)] : {512{1'bx}};
      for (int k = 0; k < 8; k++) if (we[k]) cur[k*64 +: 64] = wd[k*64 +: 64];
      m_mem[int'(wa)] = cur;
    end
    @(posedge clk); #1;
    e = mq.pop_front();
    if (e.chk) check("main_rd", m_if.readData, e.exp);
  endtask

  task automatic tag_cycle(input logic [8:0] ra, input logic [8:0] wa,
                           input logic [49:0] wd, input logic we, input bit chk);
    sb_t e;
    t_if.readAddr = ra; t_if.writeAddr = wa; t_if.writeData = wd; t_if.writeEnable = we;
    e.chk = chk;
    e.exp = chk ? {462'b0, t_mem[int'(ra)]} : '0;
    tq.push_back(e);
    if (we) t_mem[int'(wa)] = wd;
    @(posedge clk); #1;
    e = tq.pop_front();
    if (e.chk) check("tag_rd", {462'b0, t_if.readData}, e.exp);
  endtask

  // Two-edge latency: an entry is compared once a newer one sits behind it.
  task automatic pipe_cycle(input logic [9:0] ra, input logic [9:0] wa,
                            input logic [63:0] wd, input logic we, input bit chk);
    sb_t e;
    p_if.readAddr = ra; p_if.writeAddr = wa; p_if.writeData = wd; p_if.writeEnable = we;
    e.chk = chk;
    e.exp = chk ? {448'b0, p_mem[int'(ra)]} : '0;
    pq.push_back(e);
    if (we) p_mem[int'(wa)] = wd;
    @(posedge clk); #1;
    if (pq.size() > 1) begin
      e = pq.pop_front();
      if (e.chk) check("pipe_rd", {448'b0, p_if.readData}, e.exp);
    end
  endtask

  initial begin
    logic [511:0] a_row;
    logic [511:0] b_row;
    logic [511:0] c_row;
    logic [511:0] mask_exp;

    m_if.readAddr = '0; m_if.writeAddr = '0; m_if.writeData = '0; m_if.writeEnable = '0;
    t_if.readAddr = '0; t_if.writeAddr = '0; t_if.writeData = '0; t_if.writeEnable = '0;
    p_if.readAddr = '0; p_if.writeAddr = '0; p_if.writeData = '0; p_if.writeEnable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_main", m_if.readData, 512'd0);
    check("rst_tag", {462'b0, t_if.readData}, 512'd0);
    check("rst_pipe", {448'b0, p_if.readData}, 512'd0);

    // Full-row write then read of row 5
    main_cycle(9'd5, 9'd5, {8{64'hDEAD_BEEF_0000_0001}}, 8'hFF, 1'b0);
    main_cycle(9'd5, 9'd0, 512'd0, 8'h00, 1'b1);

    // Lane mask on row 7
    main_cycle(9'd5, 9'd7, {512{1'b1}}, 8'hFF, 1'b0);
    main_cycle(9'd5, 9'd7, 512'd0, 8'b0000_0100, 1'b0);
    main_cycle(9'd7, 9'd0, 512'd0, 8'h00, 1'b1);
    mask_exp = {512{1'b1}};
    mask_exp[191:128] = 64'd0;
    check("lane_mask", m_if.readData, mask_exp);

    // Read/write collision on row 3, full and partial
    a_row = {16{32'hA5A5_0003}};
    b_row = {16{32'hB00B_1234}};
    c_row = {16{32'hC0DE_7777}};
    main_cycle(9'd5, 9'd3, a_row, 8'hFF, 1'b0);
    main_cycle(9'd3, 9'd3, b_row, 8'hFF, 1'b1);
    check("coll_old", m_if.readData, a_row);
    main_cycle(9'd3, 9'd0, 512'd0, 8'h00, 1'b1);
    main_cycle(9'd3, 9'd3, c_row, 8'h0F, 1'b1);
    main_cycle(9'd3, 9'd0, 512'd0, 8'h00, 1'b1);

    // Pipelined reads of rows 0..3 plus the wrap-around top row
    main_cycle(9'd5, 9'd0, {8{64'h0000_0000_0000_0A00}}, 8'hFF, 1'b0);
    main_cycle(9'd5, 9'd1, {8{64'h1111_0000_0000_0B01}}, 8'hFF, 1'b0);
    main_cycle(9'd5, 9'd2, {8{64'h2222_0000_0000_0C02}}, 8'hFF, 1'b0);
    main_cycle(9'd5, 9'd511, {8{64'h5110_5110_5110_5110}}, 8'hFF, 1'b0);
    for (int r = 0; r < 4; r++) main_cycle(9'(r), 9'd0, 512'd0, 8'h00, 1'b1);
    main_cycle(9'd511, 9'd0, 512'd0, 8'h00, 1'b1);

    // Asynchronous reset mid-run; writes during reset are dropped
    main_cycle(9'd5, 9'd0, 512'd0, 8'h00, 1'b1);
    pipe_cycle(10'd0, 10'd9, 64'h0909_0909_0909_0909, 1'b1, 1'b0);
    pipe_cycle(10'd9, 10'd0, 64'd0, 1'b0, 1'b0);
    pipe_cycle(10'd9, 10'd0, 64'd0, 1'b0, 1'b0);
    pq.delete();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_main", m_if.readData, 512'd0);
    check("async_rst_pipe", {448'b0, p_if.readData}, 512'd0);
    m_if.writeAddr = 9'd5; m_if.writeData = ~{8{64'hDEAD_BEEF_0000_0001}}; m_if.writeEnable = 8'hFF;
    @(posedge clk); #1;
    check("rst_hold_main", m_if.readData, 512'd0);
    @(negedge clk);
    m_if.writeEnable = 8'h00;
    reset_n = 1'b1;
    main_cycle(9'd5, 9'd0, 512'd0, 8'h00, 1'b1);
    main_cycle(9'd7, 9'd0, 512'd0, 8'h00, 1'b1);

    // Tag array: top row and row 0 independence
    tag_cycle(9'd0, 9'd0, 50'h1_2345_6789_ABCD, 1'b1, 1'b0);
    tag_cycle(9'd0, 9'd511, 50'h3_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    tag_cycle(9'd511, 9'd0, 50'd0, 1'b0, 1'b1);
    tag_cycle(9'd0, 9'd0, 50'd0, 1'b0, 1'b1);
    tag_cycle(9'd511, 9'd511, 50'h0_0000_0000_0001, 1'b1, 1'b1);
    tag_cycle(9'd511, 9'd0, 50'd0, 1'b0, 1'b1);

    // Two-edge pipeline: back-to-back reads, collision, and drain
    for (int r = 0; r < 4; r++) pipe_cycle(10'd0, 10'(r), {16'(r + 1), 48'hFACE_0000_0000}, 1'b1, 1'b0);
    pipe_cycle(10'd0, 10'd1023, 64'h7FF0_0000_0000_03FF, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) pipe_cycle(10'(r), 10'd0, 64'd0, 1'b0, 1'b1);
    pipe_cycle(10'd1023, 10'd2, 64'hBEEF_0000_0000_0002, 1'b1, 1'b1);
    pipe_cycle(10'd2, 10'd2, 64'hCAFE_0000_0000_0002, 1'b1, 1'b1);
    pipe_cycle(10'd2, 10'd0, 64'd0, 1'b0, 1'b1);
    pipe_cycle(10'd0, 10'd0, 64'd0, 1'b0, 1'b0);
    pipe_cycle(10'd0, 10'd0, 64'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
